// File: rtl/cu_pkg.sv
// cu_pkg
//   Shared constants for the multicycle RISC-V control unit.
//   - S_* : the 16 legal 5-bit state encodings of the CU state register.
//   - OP_*: 7-bit base opcodes (IR[6:0]). The output decoder and the ALU
//           control use the same constants.
package cu_pkg;

    typedef logic [4:0] cu_state_t;
    typedef logic [6:0] cu_opcode_t;

    // State encodings
    localparam cu_state_t S_FETCH    = 5'd0;
    localparam cu_state_t S_DECODE   = 5'd1;
    localparam cu_state_t S_MEMADR   = 5'd2;
    localparam cu_state_t S_MEMREAD  = 5'd3;
    localparam cu_state_t S_MEMWB    = 5'd4;
    localparam cu_state_t S_MEMWRITE = 5'd5;
    localparam cu_state_t S_EXECUTER = 5'd6;
    localparam cu_state_t S_ALUWB    = 5'd7;
    localparam cu_state_t S_BRANCH   = 5'd8;
    localparam cu_state_t S_JUMP     = 5'd9;
    localparam cu_state_t S_JAL      = 5'd10;
    localparam cu_state_t S_AUIPC    = 5'd11;
    localparam cu_state_t S_JALR     = 5'd12;
    localparam cu_state_t S_EXECUTEI = 5'd13;
    localparam cu_state_t S_BRDONE   = 5'd14;
    localparam cu_state_t S_LUI      = 5'd15;

    // Opcodes
    localparam cu_opcode_t OP_LOAD   = 7'b0000011;
    localparam cu_opcode_t OP_STORE  = 7'b0100011;
    localparam cu_opcode_t OP_R      = 7'b0110011;
    localparam cu_opcode_t OP_BRANCH = 7'b1100011;
    localparam cu_opcode_t OP_JAL    = 7'b1101111;
    localparam cu_opcode_t OP_JALR   = 7'b1100111;
    localparam cu_opcode_t OP_OPIMM  = 7'b0010011;
    localparam cu_opcode_t OP_LUI    = 7'b0110111;
    localparam cu_opcode_t OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/cu_state_sequencer_if.sv
// cu_state_sequencer_if
//   Bundle between the instruction register side and the CU sequencer.
//   opcode        : IR[6:0]
//   stall         : 1 = freeze the sequencer for this cycle
//   StateRegister : current CU state (to the output decoder)
//   instr_done    : one-cycle retirement pulse
//   illegal_op    : sticky illegal-opcode flag
//   retired_count : retired-instruction counter, CNT_W bits
//   master = IR/stall source (and observer), slave = sequencer.
interface cu_state_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             stall;
    logic [4:0]       StateRegister;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output opcode, stall,
        input  StateRegister, instr_done, illegal_op, retired_count
    );

    modport slave (
        input  opcode, stall,
        output StateRegister, instr_done, illegal_op, retired_count
    );
endinterface

// File: rtl/cu_next_state.sv
// cu_next_state
//   Purely combinational next-state table of the CU sequencer.
//   Ports:
//     state      in  5  current state
//     opcode     in  7  IR[6:0]; only looked at in S1, S2 and S9
//     next_state out 5  state to load on the next unstalled edge
//     is_illegal out 1  this transition is an illegal fall-back to S0
//     is_retire  out 1  this transition retires an instruction
module cu_next_state
    import cu_pkg::*;
(
    input  cu_state_t  state,
    input  cu_opcode_t opcode,
    output cu_state_t  next_state,
    output logic       is_illegal,
    output logic       is_retire
);

    always_comb begin
        // Anything not explicitly routed goes back to fetch.
        next_state = S_FETCH;
        is_illegal = 1'b0;
        is_retire  = 1'b0;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXECUTER;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL, OP_JALR:   next_state = S_JUMP;
                    OP_OPIMM:          next_state = S_EXECUTEI;
                    OP_AUIPC:          next_state = S_AUIPC;
                    OP_LUI:            next_state = S_LUI;
                    default:           is_illegal = 1'b1;
                endcase
            end
            // The opcode is re-checked here; a changed IR aborts the
            // instruction rather than guessing a path.
            S_MEMADR: begin
                if (opcode == OP_LOAD)       next_state = S_MEMREAD;
                else if (opcode == OP_STORE) next_state = S_MEMWRITE;
                else                         is_illegal = 1'b1;
            end
            S_JUMP: begin
                if (opcode == OP_JAL)       next_state = S_JAL;
                else if (opcode == OP_JALR) next_state = S_JALR;
                else                        is_illegal = 1'b1;
            end
            S_MEMREAD: next_state = S_MEMWB;
            S_EXECUTER, S_AUIPC, S_EXECUTEI, S_LUI: next_state = S_ALUWB;
            S_BRANCH:  next_state = S_BRDONE;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_JAL, S_JALR, S_BRDONE:
                is_retire = 1'b1;
            // Encodings 16..31 should never be reached; recover to fetch.
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cu_state_sequencer.sv
// cu_state_sequencer
//   State register and bookkeeping of the multicycle RISC-V control unit.
//   Ports:
//     clk      in  1    rising-edge clock
//     reset_n  in  1    asynchronous active-low reset
//     bus      slave modport of cu_state_sequencer_if (opcode, stall in;
//              StateRegister, instr_done, illegal_op, retired_count out)
//   The transition table lives in cu_next_state; this module holds the
//   state, the retirement pulse, the sticky illegal flag and the counter.
module cu_state_sequencer
    import cu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cu_state_sequencer_if.slave  bus
);

    cu_state_t        state_q, state_d;
    logic             done_q, done_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    cu_state_t        ns;
    logic             ns_illegal;
    logic             ns_retire;

    cu_next_state u_next (
        .state      (state_q),
        .opcode     (bus.opcode),
        .next_state (ns),
        .is_illegal (ns_illegal),
        .is_retire  (ns_retire)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;     // pulse drops on every stalled cycle too
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        if (!bus.stall) begin
            state_d = ns;
            done_d  = ns_retire;
            if (ns_retire)  cnt_d = cnt_q + CNT_W'(1);
            if (ns_illegal) ill_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.StateRegister = state_q;
    assign bus.instr_done    = done_q;
    assign bus.illegal_op    = ill_q;
    assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_cu_state_sequencer.sv
module tb_cu_state_sequencer;
    import cu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] opcode;
    logic       stall;

    always #5 clk = ~clk;

    // Two DUTs share stimulus: full-width counter and a 4-bit one for wrap.
    cu_state_sequencer_if #(.CNT_W(32)) ifa ();
    cu_state_sequencer_if #(.CNT_W(4))  ifb ();
    assign ifa.opcode = opcode;
    assign ifa.stall  = stall;
    assign ifb.opcode = opcode;
    assign ifb.stall  = stall;

    cu_state_sequencer #(.CNT_W(32)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    cu_state_sequencer #(.CNT_W(4))  dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

    int vectors = 0;
    int fails   = 0;

    // Reference model: an instruction is a list of states to visit after S0.
    int          exp_state;
    bit          exp_done;
    bit          exp_ill;
    int unsigned exp_cnt;
    int          path_q[$];
    bit          cur_legal;
    logic [6:0]  cur_op1, cur_op2;
    int          done_seen_b = 0;

    logic [6:0] legal_ops [9] = '{OP_LOAD, OP_STORE, OP_R, OP_BRANCH, OP_JAL,
                                  OP_JALR, OP_OPIMM, OP_LUI, OP_AUIPC};
    logic [6:0] two_step_ops [4] = '{OP_LOAD, OP_STORE, OP_JAL, OP_JALR};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("A.state", 32'(ifa.StateRegister), exp_state);
        chk("A.done",  32'(ifa.instr_done),    32'(exp_done));
        chk("A.ill",   32'(ifa.illegal_op),    32'(exp_ill));
        chk("A.cnt",   ifa.retired_count,      exp_cnt);
        chk("B.state", 32'(ifb.StateRegister), exp_state);
        chk("B.done",  32'(ifb.instr_done),    32'(exp_done));
        chk("B.ill",   32'(ifb.illegal_op),    32'(exp_ill));
        chk("B.cnt",   32'(ifb.retired_count), exp_cnt % 16);
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        exp_state = 0; exp_done = 0; exp_ill = 0; exp_cnt = 0;
        path_q.delete();
    endtask

    // a = opcode seen in S1, b = opcode seen in S2/S9
    task automatic load_instr(input logic [6:0] a, input logic [6:0] b);
        cur_op1 = a; cur_op2 = b; cur_legal = 1'b1;
        path_q.delete();
        if (a == OP_LOAD || a == OP_STORE) begin
            path_q = '{1, 2};
            if (b == OP_LOAD)       begin path_q.push_back(3); path_q.push_back(4); end
            else if (b == OP_STORE) path_q.push_back(5);
            else                    cur_legal = 1'b0;
        end else if (a == OP_JAL || a == OP_JALR) begin
            path_q = '{1, 9};
            if (b == OP_JAL)       path_q.push_back(10);
            else if (b == OP_JALR) path_q.push_back(12);
            else                   cur_legal = 1'b0;
        end else if (a == OP_R)      path_q = '{1, 6, 7};
        else if (a == OP_BRANCH)     path_q = '{1, 8, 14};
        else if (a == OP_OPIMM)      path_q = '{1, 13, 7};
        else if (a == OP_AUIPC)      path_q = '{1, 11, 7};
        else if (a == OP_LUI)        path_q = '{1, 15, 7};
        else begin path_q = '{1}; cur_legal = 1'b0; end
    endtask

    // One clock: drive, advance the model at the edge, check at negedge.
    task automatic step(input bit st);
        stall  = st;
        opcode = (exp_state <= 1) ? cur_op1 : cur_op2;
        @(posedge clk);
        if (st) exp_done = 1'b0;
        else if (path_q.size() > 0) begin
            exp_state = path_q.pop_front();
            exp_done  = 1'b0;
        end else begin
            exp_state = 0;
            if (cur_legal) begin exp_done = 1'b1; exp_cnt++; end
            else begin exp_done = 1'b0; exp_ill = 1'b1; end
        end
        @(negedge clk);
        if (ifb.instr_done === 1'b1) done_seen_b++;
        check_all();
    endtask

    task automatic run_instr(input logic [6:0] a, input logic [6:0] b, input int stall_pct);
        int n = 0;
        load_instr(a, b);
        while ((path_q.size() > 0 || exp_state != 0) && n < 500) begin
            step($urandom_range(99) < stall_pct);
            n++;
        end
        $display("instr op1=%b op2=%b legal=%0d cycles=%0d retired=%0d illegal_op=%0d",
                 a, b, cur_legal, n, exp_cnt, exp_ill);
    endtask

    initial begin
        int r;
        int pulses0;
        logic [6:0] a, b;

        reset_n = 1'b0; stall = 1'b1; opcode = 7'd0;
        cur_op1 = 7'd0; cur_op2 = 7'd0; cur_legal = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        reset_n = 1'b1;
        @(negedge clk);
        check_all();

        // LOAD, then STORE and JALR back to back
        run_instr(OP_LOAD, OP_LOAD, 0);
        run_instr(OP_STORE, OP_STORE, 0);
        run_instr(OP_JALR, OP_JALR, 0);

        // illegal opcode in S1, then a legal R-type
        run_instr(7'b1111111, 7'b1111111, 0);
        run_instr(OP_R, OP_R, 0);

        // path mismatches in S2 and S9
        run_instr(OP_LOAD, OP_R, 0);
        run_instr(OP_JAL, OP_BRANCH, 0);

        // BRANCH with a 3-cycle stall in S8 and a stall in the terminal state
        load_instr(OP_BRANCH, OP_BRANCH);
        step(0); step(0);
        step(1); step(1); step(1);
        step(0); step(1); step(0);
        $display("instr op1=%b stalled branch retired=%0d", OP_BRANCH, exp_cnt);

        // async reset mid S3
        load_instr(OP_LOAD, OP_LOAD);
        step(0); step(0); step(0);
        stall = 1'b1;
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
        @(negedge clk);
        check_all();
        $display("reset mid-S3 applied, fetch resumes at S0");
        run_instr(OP_OPIMM, OP_OPIMM, 0);

        // 16 LUI instructions: 4-bit counter wraps back to its start value
        pulses0 = done_seen_b;
        repeat (16) run_instr(OP_LUI, OP_LUI, 0);
        chk("B.done_pulses", done_seen_b - pulses0, 16);

        // randomized instructions with random stalls
        repeat (200) begin
            r = $urandom_range(99);
            if (r < 12) begin
                do a = 7'($urandom_range(127)); while (is_legal(a));
                b = a;
            end else if (r < 30) begin
                a = two_step_ops[$urandom_range(3)];
                b = 7'($urandom_range(127));
            end else begin
                a = legal_ops[$urandom_range(8)];
                b = a;
            end
            run_instr(a, b, 25);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
